approx_mult_error_monitor: RTL

//  Downstream characterisation stage for the 4x4 approximate multiplier. Consumes

---
 rtl/approx_mult_error_monitor.sv | 136 +++++++++++++
 1 files changed

// File: rtl/approx_mult_error_monitor.sv
// Error-statistics monitor for a WIDTH x WIDTH approximate multiplier: two-stage pipeline
// (operand/exact-product register, then stats update) over a programmable sample window.
module approx_mult_error_monitor #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16,
    parameter int ACC_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_in,
    input  logic [CNT_W-1:0]   window_len_in,
    input  logic               valid_in,
    output logic               ready_out,
    input  logic [WIDTH-1:0]   m_in,
    input  logic [WIDTH-1:0]   n_in,
    input  logic [2*WIDTH-1:0] approx_in,
    output logic               busy_out,
    output logic               done_out,
    output logic [CNT_W-1:0]   sample_cnt_out,
    output logic [CNT_W-1:0]   err_cnt_out,
    output logic [ACC_W-1:0]   sum_ed_out,
    output logic [2*WIDTH-1:0] max_ed_out,
    output logic [WIDTH-1:0]   max_m_out,
    output logic [WIDTH-1:0]   max_n_out
);
    localparam int PW = 2 * WIDTH;
    localparam int SW = ACC_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   win_len_q, acc_cnt_q;
    logic               s1_vld_q;
    logic [WIDTH-1:0]   s1_m_q, s1_n_q;
    logic [PW-1:0]      s1_approx_q, s1_exact_q;
    logic [CNT_W-1:0]   sample_cnt_q, err_cnt_q;
    logic [ACC_W-1:0]   sum_ed_q;
    logic [PW-1:0]      max_ed_q;
    logic [WIDTH-1:0]   max_m_q, max_n_q;

    logic               accept, last_accept, start_acc;
    logic [PW-1:0]      exact_w, ed;
    logic [SW-1:0]      sum_ext;
    logic [ACC_W-1:0]   sum_sat;

    assign start_acc   = start_in && (state_q == IDLE);
    assign accept      = valid_in && (state_q == RUN);
    assign last_accept = accept && ((acc_cnt_q + CNT_W'(1)) == win_len_q);
    assign exact_w     = PW'(m_in) * PW'(n_in);

    assign ed      = (s1_exact_q >= s1_approx_q) ? (s1_exact_q - s1_approx_q)
                                                 : (s1_approx_q - s1_exact_q);
    assign sum_ext = {1'b0, sum_ed_q} + SW'(ed);
    // Carry out of the accumulator means we clamp at all-ones and stay there.
    assign sum_sat = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_in) state_d = (window_len_in == '0) ? DONE : RUN;
            RUN:     if (last_accept) state_d = DRAIN;
            DRAIN:   if (!s1_vld_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_out = (state_q == RUN);
        busy_out  = (state_q == RUN) || (state_q == DRAIN);
        done_out  = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_len_q   <= '0;
            acc_cnt_q   <= '0;
            s1_vld_q    <= 1'b0;
            s1_m_q      <= '0;
            s1_n_q      <= '0;
            s1_approx_q <= '0;
            s1_exact_q  <= '0;
        end else begin
            s1_vld_q <= accept;
            if (start_acc) begin
                win_len_q <= window_len_in;
                acc_cnt_q <= '0;
            end else if (accept) begin
                acc_cnt_q <= acc_cnt_q + CNT_W'(1);
            end
            if (accept) begin
                s1_m_q      <= m_in;
                s1_n_q      <= n_in;
                s1_approx_q <= approx_in;
                s1_exact_q  <= exact_w;
            end
        end
    end

    // Stage 2: fold the registered sample into the window statistics.
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            sum_ed_q     <= '0;
            max_ed_q     <= '0;
            max_m_q      <= '0;
            max_n_q      <= '0;
        end else if (s1_vld_q) begin
            sample_cnt_q <= sample_cnt_q + CNT_W'(1);
            err_cnt_q    <= err_cnt_q + CNT_W'(ed != '0);
            sum_ed_q     <= sum_sat;
            if (ed > max_ed_q) begin
                max_ed_q <= ed;
                max_m_q  <= s1_m_q;
                max_n_q  <= s1_n_q;
            end
        end
    end

    assign sample_cnt_out = sample_cnt_q;
    assign err_cnt_out    = err_cnt_q;
    assign sum_ed_out     = sum_ed_q;
    assign max_ed_out     = max_ed_q;
    assign max_m_out      = max_m_q;
    assign max_n_out      = max_n_q;

endmodule
